// File: rtl/uart2wifi_core_pkg.sv
// Shared types and constants for the uart2wifi core slice.
package uart2wifi_core_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart2wifi_core_rr_pick.sv
// Combinational winner select: round-robin from rr_ptr, or lowest index in fixed mode.
module uart2wifi_core_rr_pick
  import uart2wifi_core_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       fixed,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   lo_mask;
  logic [2*NUM_REQ-1:0] dbl_valid;

  // Lower copy drops requesters below the pointer; the upper copy supplies the wrap-around.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign lo_mask[gi] = fixed | (ID_W'(gi) >= rr_ptr);
  end

  assign dbl_valid = {valid, valid & lo_mask};

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
      if (dbl_valid[j]) begin
        found = 1'b1;
        idx   = ID_W'(j % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart2wifi_core_tx_arbiter.sv
// Packet-granular arbiter sharing the UART TX FIFO write port between NUM_REQ byte streams,
// with a packet-length watchdog that forces release of runaway sources.
module uart2wifi_core_tx_arbiter
  import uart2wifi_core_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = UART_DATA_W,
  parameter int MAX_PKT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_full,
  output logic                       tx_wr,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       cfg_fixed_prio,
  input  logic                       err_clr,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_overrun,
  output logic [$clog2(NUM_REQ)-1:0] err_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  arb_state_t       state_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic             fixed_reg;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              handshake;
  logic              at_limit;
  logic              release_pkt;
  logic              forced;

  uart2wifi_core_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .valid (req_valid),
    .rr_ptr(rr_ptr_reg),
    .fixed (cfg_fixed_prio),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = req_data[int'(grant_id) * DATA_W +: DATA_W];

  // Ready and write strobe share the same !tx_full term, so a byte is never written into a full FIFO.
  assign handshake   = (state_reg == ARB_XFER) & g_valid & ~tx_full;
  assign at_limit    = (byte_cnt_reg == CNT_LAST);
  assign release_pkt = handshake & (g_last | at_limit);
  assign forced      = handshake & ~g_last & at_limit;

  always_comb begin
    req_ready = '0;
    if (state_reg == ARB_XFER) begin
      req_ready[grant_id] = ~tx_full;
    end
  end

  assign tx_wr   = handshake;
  assign tx_data = handshake ? g_data : '0;
  assign busy    = (state_reg == ARB_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      rr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      fixed_reg    <= 1'b0;
      grant_id     <= '0;
      err_overrun  <= 1'b0;
      err_id       <= '0;
    end else begin
      if (state_reg == ARB_IDLE) begin
        byte_cnt_reg <= '0;
        if (pick_found) begin
          grant_id  <= pick_idx;
          fixed_reg <= cfg_fixed_prio;
          state_reg <= ARB_XFER;
        end
      end else begin
        if (handshake) begin
          byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
        end
        if (release_pkt) begin
          state_reg    <= ARB_IDLE;
          byte_cnt_reg <= '0;
          if (!fixed_reg) begin
            rr_ptr_reg <= (grant_id == ID_MAX) ? '0 : grant_id + ID_W'(1);
          end
        end
      end

      // A clear wins over a coincident overrun; only the first overrun's source is kept.
      if (err_clr) begin
        err_overrun <= 1'b0;
        err_id      <= '0;
      end else if (forced && !err_overrun) begin
        err_overrun <= 1'b1;
        err_id      <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart2wifi_core_tx_arbiter.sv
// Randomized bench for the TX arbiter: packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart2wifi_core_tx_arbiter;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int MP = 64;
  localparam int IW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic              tx_full = 1'b0;
  logic              tx_wr;
  logic [DW-1:0]     tx_data;
  logic              cfg_fixed_prio = 1'b0;
  logic              err_clr = 1'b0;
  logic              busy;
  logic [IW-1:0]     grant_id;
  logic              err_overrun;
  logic [IW-1:0]     err_id;

  uart2wifi_core_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_W (DW),
    .MAX_PKT(MP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_full       (tx_full),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .cfg_fixed_prio(cfg_fixed_prio),
    .err_clr       (err_clr),
    .busy          (busy),
    .grant_id      (grant_id),
    .err_overrun   (err_overrun),
    .err_id        (err_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } txrec_t;
  typedef struct {
    int id;
    int len;
  } gnt_t;

  beat_t  src_q[NR][$];
  txrec_t tx_log[$];
  gnt_t   gnt_log[$];

  int checks = 0;
  int failures = 0;

  // Stimulus controls (written by the main sequence, read by the driver)
  bit hold[NR];
  bit hold_rand = 1'b0;
  bit full_rand = 1'b0;
  bit full_force = 1'b0;

  // Reference model state: which source owns the port, bytes so far, next round-robin start
  bit          m_xfer = 1'b0;
  int          m_g = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_fixed = 1'b0;
  bit          m_err = 1'b0;
  int          m_err_id = 0;
  logic [NR-1:0] exp_hs = '0;

  int cyc = 0;
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;
  int v0_rise_cyc = 0;
  int cur_len = 0;
  int last_gid = 0;
  bit prev_busy = 1'b0;
  bit prev_v0 = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, expv, cyc);
    end
  endfunction

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Driver: pop accepted beats, present the next head (or garbage when idle), and shape tx_full.
  initial begin
    bit hold_now;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (exp_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        hold_now = hold[i] || (hold_rand && $urandom_range(0, 3) == 0);
        if (src_q[i].size() > 0 && !hold_now) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0].data;
          req_last[i]          = src_q[i][0].last;
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*DW +: DW] = 8'($urandom);
          req_last[i]          = 1'($urandom);
        end
      end
      tx_full = full_force || (full_rand && $urandom_range(0, 3) == 0);
    end
  end

  // Compare process: predict outputs from the model, compare, then advance the model.
  always @(negedge clk) begin
    logic [NR-1:0] e_ready;
    logic [7:0]    e_data;
    bit            hs;
    bit            fnd;
    bit            forced;
    int            start;
    int            win;
    cyc++;
    hs     = 1'b0;
    forced = 1'b0;
    win    = 0;
    if (rst) begin
      chk("busy", busy, 0);
      chk("grant_id", grant_id, 0);
      chk("req_ready", req_ready, 0);
      chk("tx_wr", tx_wr, 0);
      chk("tx_data", tx_data, 0);
      chk("err_overrun", err_overrun, 0);
      chk("err_id", err_id, 0);
      m_xfer = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_fixed = 0; m_err = 0; m_err_id = 0;
      exp_hs = '0;
    end else begin
      e_ready = '0;
      if (m_xfer) begin
        if (!tx_full) e_ready[m_g] = 1'b1;
        hs = req_valid[m_g] && !tx_full;
      end
      e_data = hs ? req_data[m_g*DW +: DW] : 8'h00;
      chk("busy", busy, m_xfer);
      chk("grant_id", grant_id, m_g);
      chk("req_ready", req_ready, e_ready);
      chk("tx_wr", tx_wr, hs);
      chk("tx_data", tx_data, e_data);
      chk("err_overrun", err_overrun, m_err);
      chk("err_id", err_id, m_err_id);
      exp_hs = '0;
      if (hs) exp_hs[m_g] = 1'b1;

      if (!m_xfer) begin
        start = cfg_fixed_prio ? 0 : m_ptr;
        fnd   = 1'b0;
        for (int k = 0; k < NR; k++) begin
          if (!fnd && req_valid[(start + k) % NR]) begin
            fnd = 1'b1;
            win = (start + k) % NR;
          end
        end
        if (fnd) begin
          m_xfer = 1; m_g = win; m_fixed = cfg_fixed_prio; m_cnt = 0;
        end
      end else if (hs) begin
        m_cnt++;
        forced = !req_last[m_g] && (m_cnt == MP);
        if (req_last[m_g] || m_cnt == MP) begin
          m_xfer = 0;
          m_cnt  = 0;
          if (!m_fixed) m_ptr = (m_g + 1) % NR;
        end
      end
      if (err_clr) begin
        m_err = 0; m_err_id = 0;
      end else if (forced && !m_err) begin
        m_err = 1; m_err_id = m_g;
      end
    end

    if (tx_wr) begin
      tx_log.push_back('{cyc, tx_data});
      cur_len++;
    end
    if (req_valid[0] && !prev_v0) v0_rise_cyc = cyc;
    if (busy && !prev_busy) busy_rise_cyc = cyc;
    if (busy) last_gid = int'(grant_id);
    if (!busy && prev_busy) begin
      busy_fall_cyc = cyc;
      gnt_log.push_back('{last_gid, cur_len});
      $display("pkt: req=%0d bytes=%0d err_overrun=%0d err_id=%0d cycle=%0d",
               last_gid, cur_len, err_overrun, err_id, cyc);
      cur_len = 0;
    end
    prev_busy = busy;
    prev_v0   = req_valid[0];
  end

  task automatic push_pkt(input int r, input int len, input int base);
    for (int i = 0; i < len; i++) src_q[r].push_back('{last: (i == len - 1), data: 8'(base + i)});
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk); #1;
      k++;
      done = !busy && queues_empty();
    end
    chk(name, done, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, tx_log.size() >= n, 1);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      hold[i] = 1'b0;
    end
  endtask

  initial begin
    int rr_exp[4];
    int fx_exp[4];
    int r;
    int len;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err_overrun", err_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single 3-byte packet on req0
    tx_log.delete();
    gnt_log.delete();
    push_pkt(0, 3, 8'h61);
    drain(200, "t2_drain");
    chk("t2_nbytes", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("t2_byte0", tx_log[0].data, 8'h61);
      chk("t2_byte1", tx_log[1].data, 8'h62);
      chk("t2_byte2", tx_log[2].data, 8'h63);
      chk("t2_consec", tx_log[2].cyc - tx_log[0].cyc, 2);
      chk("t2_busy_latency", busy_rise_cyc - v0_rise_cyc, 1);
      chk("t2_first_wr", tx_log[0].cyc - busy_rise_cyc, 0);
      chk("t2_busy_fall", busy_fall_cyc - tx_log[2].cyc, 1);
    end

    // Overrun on req1: 70 bytes, last only on the 70th
    gnt_log.delete();
    push_pkt(1, 70, 0);
    drain(600, "t5_drain");
    chk("t5_ngrants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t5_g0_id", gnt_log[0].id, 1);
      chk("t5_g0_len", gnt_log[0].len, 64);
      chk("t5_g1_id", gnt_log[1].id, 1);
      chk("t5_g1_len", gnt_log[1].len, 6);
    end
    chk("t5_err_overrun", err_overrun, 1);
    chk("t5_err_id", err_id, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk); #1;
    chk("t5_err_clr", err_overrun, 0);
    chk("t5_err_id_clr", err_id, 0);

    // Second overrun from req2 re-arms the sticky flag
    gnt_log.delete();
    push_pkt(2, 66, 8'h80);
    drain(600, "t5b_drain");
    chk("t5b_err_overrun", err_overrun, 1);
    chk("t5b_err_id", err_id, 2);

    // Reset in the middle of a packet
    tx_log.delete();
    push_pkt(0, 10, 8'h10);
    wait_tx(3, 100, "t1_wait");
    chk("t1_busy_before", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    flush_sources();
    @(negedge clk); #1;
    chk("t1_busy", busy, 0);
    chk("t1_req_ready", req_ready, 0);
    chk("t1_tx_wr", tx_wr, 0);
    chk("t1_err_overrun", err_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Round-robin between req0 and req1, then fixed priority
    rr_exp = '{0, 1, 0, 1};
    fx_exp = '{0, 0, 1, 1};
    gnt_log.delete();
    push_pkt(0, 2, 8'h20); push_pkt(0, 2, 8'h22);
    push_pkt(1, 2, 8'h30); push_pkt(1, 2, 8'h32);
    drain(200, "t3_rr_drain");
    chk("t3_rr_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      chk("t3_rr_grant", gnt_log[i].id, rr_exp[i]);
      chk("t3_rr_len", gnt_log[i].len, 2);
    end
    cfg_fixed_prio = 1'b1;
    gnt_log.delete();
    push_pkt(0, 2, 8'h24); push_pkt(0, 2, 8'h26);
    push_pkt(1, 2, 8'h34); push_pkt(1, 2, 8'h36);
    drain(200, "t3_fx_drain");
    chk("t3_fx_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      chk("t3_fx_grant", gnt_log[i].id, fx_exp[i]);
    end
    cfg_fixed_prio = 1'b0;

    // Backpressure: tx_full for 5 cycles mid-packet
    tx_log.delete();
    push_pkt(0, 8, 8'h40);
    wait_tx(2, 100, "t4_wait");
    @(posedge clk); #1;
    full_force = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("t4_ready_low", req_ready, 0);
      chk("t4_no_wr", tx_wr, 0);
    end
    @(posedge clk); #1;
    full_force = 1'b0;
    drain(200, "t4_drain");
    chk("t4_nbytes", tx_log.size(), 8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++) chk("t4_byte", tx_log[i].data, 8'h40 + i);

    // Granted source stalls while req0 waits
    tx_log.delete();
    gnt_log.delete();
    push_pkt(1, 6, 8'h70);
    wait_tx(2, 100, "t6_wait");
    @(posedge clk); #1;
    hold[1] = 1'b1;
    push_pkt(0, 2, 8'h50);
    repeat (3) begin
      @(negedge clk); #1;
      chk("t6_busy", busy, 1);
      chk("t6_grant", grant_id, 1);
      chk("t6_ready0", req_ready[0], 0);
      chk("t6_no_wr", tx_wr, 0);
    end
    @(posedge clk); #1;
    hold[1] = 1'b0;
    drain(200, "t6_drain");
    chk("t6_ngrants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t6_g0", gnt_log[0].id, 1);
      chk("t6_g0_len", gnt_log[0].len, 6);
      chk("t6_g1", gnt_log[1].id, 0);
    end

    // Randomized traffic against the model
    hold_rand = 1'b1;
    full_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r   = $urandom_range(0, NR - 1);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 75) : $urandom_range(1, 12);
      push_pkt(r, len, $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cfg_fixed_prio = ~cfg_fixed_prio;
      if ($urandom_range(0, 5) == 0) err_clr = 1'b1;
      repeat ($urandom_range(1, 15)) @(posedge clk);
      #1;
      err_clr = 1'b0;
      if (it == 20) begin
        rst = 1'b1;
        flush_sources();
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    drain(20000, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
